// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and the
//   bit-counter width helper.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_e;

  // Bit counter must hold 0..w-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// fa_cell
//   Purely combinational 1-bit full adder, the only arithmetic in the serial adder.
// Ports
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: captures two WIDTH-bit operands and a carry-in on a start
//   handshake, then adds them LSB-first one bit per clock through a single
//   full-adder cell. Produces the WIDTH-bit sum, the carry-out and a one-cycle
//   done pulse. {carry,sum} == a_in + b_in + c_in.
// Optional feature (macro SERIAL_ADDER_SUB_EN)
//   Adds input sub_in, sampled on accept. When set, B is inverted on capture
//   and the carry register is loaded with ~c_in so the result is
//   a_in - b_in - c_in; carry then reports borrow-out.
// Ports
//   clk_in   : clock, rising edge
//   rst_in   : synchronous active-high reset, overrides everything
//   start_in : request, accepted only while ready=1
//   a_in/b_in: operands, sampled on accept
//   c_in     : carry-in (borrow-in when subtracting), sampled on accept
//   ready    : high in IDLE
//   sum      : result, valid from done until next accept
//   carry    : carry-out / borrow-out
//   done     : one-cycle pulse when sum/carry become valid
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_next;
  logic             sub_cap;   // subtract request at the accept edge
  logic             sub_run;   // subtract mode of the operation in flight

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  assign sub_cap = sub_in;
  assign sub_run = sub_q;
`else
  assign sub_cap = 1'b0;
  assign sub_run = 1'b0;
`endif

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ready   = 1'b0;
    done    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start_in) begin
          a_sr_d  = a_in;
          // Subtraction as a + ~b + ~c_in: two's complement with borrow-in.
          b_sr_d  = b_in ^ {WIDTH{sub_cap}};
          cy_d    = c_in ^ sub_cap;
          cnt_d   = '0;
          state_d = S_ADD;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = sub_cap;
`endif
        end
      end
      S_ADD: begin
        res_d  = res_next;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cy_d   = fa_co;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_next;
          // In subtract mode a missing final carry means a borrow occurred.
          carry_d = fa_co ^ sub_run;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Operand/result shift registers carry no reset: they are always reloaded
  // on accept before being used.
  always_ff @(posedge clk_in) begin
    a_sr_q <= a_sr_d;
    b_sr_q <= b_sr_d;
    res_q  <= res_d;
    cy_q   <= cy_d;
`ifdef SERIAL_ADDER_SUB_EN
    sub_q  <= sub_d;
`endif
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule
